// File: rtl/dtree_vote_if.sv
// Classifier-result stream into the vote filter and voted class back out.
interface dtree_vote_if;
  logic       in_valid;
  logic [3:0] class_in;
  logic       flush;
  logic       out_valid;
  logic [3:0] out;
  logic       window_full;

  modport master (
    output in_valid, class_in, flush,
    input  out_valid, out, window_full
  );

  modport slave (
    input  in_valid, class_in, flush,
    output out_valid, out, window_full
  );
endinterface

// File: rtl/dtree_vote_filter.sv
// Sliding-window majority vote over the decision-tree class stream.
// Stage 1 maintains the window and per-class counts; stage 2 registers the argmax.
module dtree_vote_filter #(
  parameter int WIN    = 8,
  parameter int NCLASS = 16
) (
  input  logic         clk,
  input  logic         rst,
  dtree_vote_if.slave  bus
);
  localparam int CW = $clog2(WIN + 1);
  localparam int PW = (WIN > 1) ? $clog2(WIN) : 1;

  logic [3:0]    buffer [WIN];
  logic [PW-1:0] wr_ptr_p1;
  logic [CW-1:0] fill_p1;
  logic [CW-1:0] cnt_p1 [NCLASS];
  logic          vld_p1;

  logic          accept;
  logic          full;
  logic [3:0]    evict;
  logic [3:0]    vote;
  logic [CW-1:0] best;

  assign accept = bus.in_valid && !bus.flush;
  assign full   = (fill_p1 == CW'(WIN));
  assign evict  = buffer[wr_ptr_p1];

  // Stage 1: window storage, fill/pointer bookkeeping, per-class counts
  always_ff @(posedge clk) begin
    if (accept) buffer[wr_ptr_p1] <= bus.class_in;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr_p1 <= '0;
      fill_p1   <= '0;
      vld_p1    <= 1'b0;
      for (int i = 0; i < NCLASS; i++) cnt_p1[i] <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept) begin
        wr_ptr_p1 <= (wr_ptr_p1 == PW'(WIN - 1)) ? '0 : wr_ptr_p1 + 1'b1;
        if (!full) fill_p1 <= fill_p1 + 1'b1;
        vld_p1 <= full || (fill_p1 == CW'(WIN - 1));
        // An eviction of the same class as the incoming sample is a net zero
        for (int i = 0; i < NCLASS; i++) begin
          if ((bus.class_in == 4'(i)) && !(full && (evict == 4'(i))))
            cnt_p1[i] <= cnt_p1[i] + 1'b1;
          else if (full && (evict == 4'(i)) && (bus.class_in != 4'(i)))
            cnt_p1[i] <= cnt_p1[i] - 1'b1;
        end
      end
    end
  end

  // Strict compare keeps the lowest class index on ties
  always_comb begin
    vote = '0;
    best = cnt_p1[0];
    for (int i = 1; i < NCLASS; i++) begin
      if (cnt_p1[i] > best) begin
        best = cnt_p1[i];
        vote = 4'(i);
      end
    end
  end

  // Stage 2: registered vote; flush does not cancel a result already here
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid   <= 1'b0;
      bus.out         <= '0;
      bus.window_full <= 1'b0;
    end else begin
      bus.out_valid   <= vld_p1;
      bus.window_full <= full;
      if (vld_p1) bus.out <= vote;
    end
  end
endmodule

// File: tb/tb_dtree_vote_filter.sv
// Directed bench for dtree_vote_filter with a 4-deep window.
module tb_dtree_vote_filter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  dtree_vote_if bus();

  dtree_vote_filter #(.WIN(4), .NCLASS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic v, input logic [3:0] c, input logic f);
    bus.in_valid = v;
    bus.class_in = c;
    bus.flush    = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [3:0] o);
    chk({tag, "_ov"}, {7'd0, bus.out_valid}, {7'd0, ov});
    chk({tag, "_out"}, {4'd0, bus.out}, {4'd0, o});
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.class_in = 4'd0;
    bus.flush    = 1'b0;
    @(negedge clk);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk_out("reset", 0, 0);
    chk("reset_wf", {7'd0, bus.window_full}, 8'd0);
    rst = 1'b0;

    // warm-up 3,3,5,5 then eviction with 5,5,5
    tick(1, 3, 0); chk_out("wu1", 0, 0);
    tick(1, 3, 0); chk_out("wu2", 0, 0);
    tick(1, 5, 0); chk_out("wu3", 0, 0);
    tick(1, 5, 0); chk_out("wu4", 0, 0);
    chk("wu4_wf", {7'd0, bus.window_full}, 8'd0);
    tick(1, 5, 0); chk_out("tie", 1, 3);
    chk("tie_wf", {7'd0, bus.window_full}, 8'd1);
    tick(1, 5, 0); chk_out("evict1", 1, 5);
    tick(1, 5, 0); chk_out("evict2", 1, 5);
    tick(0, 0, 0); chk_out("evict3", 1, 5);
    chk("cnt3_zero", 8'(dut.cnt_p1[3]), 8'd0);
    chk("cnt5_four", 8'(dut.cnt_p1[5]), 8'd4);
    tick(0, 0, 0); chk_out("evict_idle", 0, 5);

    // same-class eviction: 7 six times
    rst = 1'b1;
    tick(0, 0, 0);
    chk_out("rst2", 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1, 7, 0);
      chk_out("same7", (i >= 4), (i >= 4) ? 4'd7 : 4'd0);
    end
    tick(0, 0, 0); chk_out("same7_last", 1, 7);
    chk("cnt7_four", 8'(dut.cnt_p1[7]), 8'd4);
    tick(0, 0, 0); chk_out("same7_idle", 0, 7);

    // gaps and high codes: 12,_,_,12,9,_,12
    tick(0, 0, 1); chk_out("gap_flush", 0, 7);
    tick(1, 12, 0); chk_out("gap1", 0, 7);
    tick(0, 0, 0);  chk_out("gap2", 0, 7);
    tick(0, 0, 0);  chk_out("gap3", 0, 7);
    tick(1, 12, 0); chk_out("gap4", 0, 7);
    tick(1, 9, 0);  chk_out("gap5", 0, 7);
    tick(0, 0, 0);  chk_out("gap6", 0, 7);
    tick(1, 12, 0); chk_out("gap7", 0, 7);
    tick(0, 0, 0);  chk_out("gap_vote", 1, 12);
    chk("gap_wf", {7'd0, bus.window_full}, 8'd1);
    tick(0, 0, 0);  chk_out("gap_hold", 0, 12);

    // flush: 3,3,3,3 then flush with coincident 1, then 1,1,1,1
    tick(0, 0, 1); chk_out("fl_pre", 0, 12);
    for (int i = 0; i < 4; i++) begin
      tick(1, 3, 0);
      chk_out("fl_three", 0, 12);
    end
    tick(1, 1, 1); chk_out("fl_inflight", 1, 3);
    for (int i = 0; i < 4; i++) begin
      tick(1, 1, 0);
      chk_out("fl_warm", 0, 3);
    end
    chk("fl_wf", {7'd0, bus.window_full}, 8'd0);
    tick(0, 0, 0); chk_out("fl_vote", 1, 1);
    chk("fl_cnt3", 8'(dut.cnt_p1[3]), 8'd0);

    // reset in the cycle after the window-completing sample
    tick(0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 2, 0);
    rst = 1'b1;
    tick(0, 0, 0);
    chk_out("mid_rst", 0, 0);
    chk("mid_rst_wf", {7'd0, bus.window_full}, 8'd0);
    rst = 1'b0;
    tick(0, 0, 0); chk_out("mid_rst_after", 0, 0);
    tick(1, 15, 0); chk_out("rw1", 0, 0);
    tick(1, 14, 0); chk_out("rw2", 0, 0);
    tick(1, 15, 0); chk_out("rw3", 0, 0);
    tick(1, 14, 0); chk_out("rw4", 0, 0);
    tick(0, 0, 0);  chk_out("rw_vote", 1, 14);
    tick(0, 0, 0);  chk_out("rw_idle", 0, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
